// File: rtl/taxi_eth_phy_10g_tx_gbx_if.sv
// Bus between the 10G PHY TX interface, the 66:DATA_W TX gearbox and the raw-mode SERDES.
// master = upstream block source / line sink, slave = the gearbox.
interface taxi_eth_phy_10g_tx_gbx_if #(
    parameter int DATA_W = 64,
    parameter int HDR_W  = 2
);
    logic [DATA_W-1:0] in_data;
    logic              in_data_valid;
    logic [HDR_W-1:0]  in_hdr;
    logic              in_hdr_valid;
    logic              in_gbx_sync;
    logic              gbx_req_sync;
    logic              gbx_req_stall;
    logic [DATA_W-1:0] out_data;
    logic              out_data_valid;

    modport master (
        output in_data, in_data_valid, in_hdr, in_hdr_valid, in_gbx_sync,
        input  gbx_req_sync, gbx_req_stall, out_data, out_data_valid
    );

    modport slave (
        input  in_data, in_data_valid, in_hdr, in_hdr_valid, in_gbx_sync,
        output gbx_req_sync, gbx_req_stall, out_data, out_data_valid
    );
endinterface

// File: rtl/taxi_eth_phy_10g_tx_gbx.sv
// 66:DATA_W TX gearbox: packs 64b/66b blocks into line words over a 33-slot sequence.
// Optional TAXI_ETH_TX_GBX_ERR_CNT_EN adds a saturating stat_err_count output.
module taxi_eth_phy_10g_tx_gbx #(
    parameter int DATA_W   = 64,
    parameter int HDR_W    = 2,
    parameter int REQ_LEAD = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    taxi_eth_phy_10g_tx_gbx_if.slave bus,
    output logic                     stat_err
`ifdef TAXI_ETH_TX_GBX_ERR_CNT_EN
    ,
    output logic [15:0]              stat_err_count
`endif
);
    localparam int IN_W  = DATA_W + HDR_W;
    localparam int BUF_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam int SEQ_W = 6;
    localparam logic [SEQ_W-1:0] SEQ_STALL  = 6'd32;
    localparam bit               HALF_BLOCK = (DATA_W == 32);

    generate
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
            $fatal(1, "taxi_eth_phy_10g_tx_gbx: DATA_W must be 32 or 64");
        end
        if (HDR_W != 2) begin : g_bad_hdr_w
            $fatal(1, "taxi_eth_phy_10g_tx_gbx: HDR_W must be 2");
        end
        if (REQ_LEAD < 0 || REQ_LEAD > 32) begin : g_bad_req_lead
            $fatal(1, "taxi_eth_phy_10g_tx_gbx: REQ_LEAD must be 0..32");
        end
    endgenerate

    logic [SEQ_W-1:0]  seq_reg, seq_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [BUF_W-1:0]  buf_reg, buf_next;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_valid_reg;
    logic              err_reg, err_next;
    logic              armed_reg;

    logic              stall_slot;
    logic              hdr_slot;
    logic [IN_W-1:0]   in_bits;
    logic [CNT_W-1:0]  in_len;
    logic [BUF_W-1:0]  merged;
    logic              err_underrun, err_stall, err_hdr, err_sync;
    logic [SEQ_W:0]    lead_sum;
    logic [SEQ_W-1:0]  lead_slot;

    // Packing: the slot number alone decides how many bits are appended, so an
    // underrun or a bad header-valid never shifts the line alignment.
    always_comb begin
        stall_slot = (seq_reg == SEQ_STALL);
        hdr_slot   = HALF_BLOCK ? !seq_reg[0] : 1'b1;
        in_bits    = '0;
        in_len     = '0;
        if (!stall_slot) begin
            in_len = hdr_slot ? CNT_W'(IN_W) : CNT_W'(DATA_W);
            if (bus.in_data_valid) begin
                if (hdr_slot) begin
                    in_bits = {bus.in_data, bus.in_hdr};
                end else begin
                    in_bits = {{HDR_W{1'b0}}, bus.in_data};
                end
            end
        end
        merged   = buf_reg | ({{(BUF_W-IN_W){1'b0}}, in_bits} << cnt_reg);
        buf_next = merged >> DATA_W;
        cnt_next = cnt_reg + in_len - CNT_W'(DATA_W);
        seq_next = stall_slot ? '0 : seq_reg + SEQ_W'(1);
    end

    always_comb begin
        err_underrun = !stall_slot && !bus.in_data_valid;
        err_stall    = stall_slot && bus.in_data_valid;
        err_hdr      = HALF_BLOCK && !stall_slot && (bus.in_hdr_valid != hdr_slot);
        err_sync     = armed_reg && bus.in_data_valid && (bus.in_gbx_sync != (seq_reg == '0));
        err_next     = err_underrun || err_stall || err_hdr || err_sync;
    end

    always_comb begin
        lead_sum  = {1'b0, seq_reg} + 7'(REQ_LEAD);
        lead_slot = (lead_sum >= 7'd33) ? SEQ_W'(lead_sum - 7'd33) : lead_sum[SEQ_W-1:0];
    end

    assign bus.gbx_req_stall  = !rst && (lead_slot == SEQ_STALL);
    assign bus.gbx_req_sync   = !rst && (lead_slot == '0);
    assign bus.out_data       = out_data_reg;
    assign bus.out_data_valid = out_valid_reg;
    assign stat_err           = err_reg;

    // The sync check arms at the end of the first full sequence after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_reg       <= '0;
            cnt_reg       <= '0;
            buf_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            armed_reg     <= 1'b0;
        end else begin
            seq_reg       <= seq_next;
            cnt_reg       <= cnt_next;
            buf_reg       <= buf_next;
            out_data_reg  <= merged[DATA_W-1:0];
            out_valid_reg <= 1'b1;
            err_reg       <= err_next;
            if (stall_slot) begin
                armed_reg <= 1'b1;
            end
        end
    end

`ifdef TAXI_ETH_TX_GBX_ERR_CNT_EN
    logic [15:0] err_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_reg <= '0;
        end else if (err_next && (err_count_reg != 16'hFFFF)) begin
            err_count_reg <= err_count_reg + 16'd1;
        end
    end

    assign stat_err_count = err_count_reg;
`endif
endmodule

// File: tb/tb_taxi_eth_phy_10g_tx_gbx.sv
// Self-checking bench for the 66:DATA_W TX gearbox: 64-bit and 32-bit instances,
// constant first-word vectors plus a bit-serial reference model feeding a scoreboard.
module tb_taxi_eth_phy_10g_tx_gbx;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    taxi_eth_phy_10g_tx_gbx_if #(.DATA_W(64), .HDR_W(2)) bus64 ();
    taxi_eth_phy_10g_tx_gbx_if #(.DATA_W(32), .HDR_W(2)) bus32 ();
    logic stat_err64, stat_err32;
`ifdef TAXI_ETH_TX_GBX_ERR_CNT_EN
    logic [15:0] err_cnt64, err_cnt32;
`endif

    taxi_eth_phy_10g_tx_gbx #(.DATA_W(64), .HDR_W(2), .REQ_LEAD(1)) dut64 (
        .clk(clk), .rst(rst), .bus(bus64), .stat_err(stat_err64)
`ifdef TAXI_ETH_TX_GBX_ERR_CNT_EN
        , .stat_err_count(err_cnt64)
`endif
    );

    taxi_eth_phy_10g_tx_gbx #(.DATA_W(32), .HDR_W(2), .REQ_LEAD(1)) dut32 (
        .clk(clk), .rst(rst), .bus(bus32), .stat_err(stat_err32)
`ifdef TAXI_ETH_TX_GBX_ERR_CNT_EN
        , .stat_err_count(err_cnt32)
`endif
    );

    typedef struct {
        logic [63:0] word;
        logic        err;
    } exp_t;

    typedef struct {
        logic [1:0]  hdr;
        logic [63:0] data;
        logic [63:0] word0;
        logic [63:0] word1;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   mode = 64;
    int   tb_seq = 0;
    int   since_rst = 0;
    int   err_pulses = 0;
    bit   bq[$];
    exp_t exp_q[$];
    int   stall_cyc[$];
    int   sync_cyc[$];
    vec_t vecs[4];
    logic [63:0] blk32;
    logic [1:0]  hdr32;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (mode %0d, cycle %0d)", name, act, req, mode, since_rst);
        end
    endtask

    task automatic idle_inputs();
        bus64.in_data = '0; bus64.in_data_valid = 1'b0; bus64.in_hdr = '0;
        bus64.in_hdr_valid = 1'b0; bus64.in_gbx_sync = 1'b0;
        bus32.in_data = '0; bus32.in_data_valid = 1'b0; bus32.in_hdr = '0;
        bus32.in_hdr_valid = 1'b0; bus32.in_gbx_sync = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        check("rst_valid64", bus64.out_data_valid, 1'b0);
        check("rst_data64", bus64.out_data, 64'h0);
        check("rst_err64", stat_err64, 1'b0);
        check("rst_req_stall64", bus64.gbx_req_stall, 1'b0);
        check("rst_req_sync64", bus64.gbx_req_sync, 1'b0);
        check("rst_valid32", bus32.out_data_valid, 1'b0);
        check("rst_data32", {32'h0, bus32.out_data}, 64'h0);
        check("rst_err32", stat_err32, 1'b0);
`ifdef TAXI_ETH_TX_GBX_ERR_CNT_EN
        check("rst_err_cnt64", {48'h0, err_cnt64}, 64'h0);
        check("rst_err_cnt32", {48'h0, err_cnt32}, 64'h0);
`endif
        rst = 1'b0;
        bq.delete(); exp_q.delete(); stall_cyc.delete(); sync_cyc.delete();
        tb_seq = 0; since_rst = 0; err_pulses = 0;
    endtask

    // One slot: check request outputs, run the serial model, drive, then score the word.
    task automatic step(input logic dv, input logic hv, input logic [1:0] hdr,
                        input logic [63:0] data, input logic gs);
        exp_t        e;
        exp_t        got;
        logic [63:0] w;
        logic        act_stall, act_sync;
        act_stall = (mode == 64) ? bus64.gbx_req_stall : bus32.gbx_req_stall;
        act_sync  = (mode == 64) ? bus64.gbx_req_sync : bus32.gbx_req_sync;
        check("req_stall", act_stall, ((tb_seq + 1) % 33) == 32);
        check("req_sync", act_sync, ((tb_seq + 1) % 33) == 0);
        if (act_stall) stall_cyc.push_back(since_rst);
        if (act_sync) sync_cyc.push_back(since_rst);

        if (tb_seq != 32) begin
            if (mode == 64 || tb_seq % 2 == 0) begin
                for (int i = 0; i < 2; i++) bq.push_back(dv ? hdr[i] : 1'b0);
            end
            for (int i = 0; i < mode; i++) bq.push_back(dv ? data[i] : 1'b0);
        end
        w = '0;
        for (int i = 0; i < mode; i++) w[i] = (bq.size() > 0) ? bq.pop_front() : 1'b0;
        e.word = w;
        e.err  = (tb_seq != 32 && !dv) || (tb_seq == 32 && dv)
              || (mode == 32 && tb_seq != 32 && (hv != (tb_seq % 2 == 0)))
              || (since_rst >= 33 && dv && (gs != (tb_seq == 0)));
        if (e.err) err_pulses++;
        exp_q.push_back(e);

        if (mode == 64) begin
            bus64.in_data = data; bus64.in_data_valid = dv; bus64.in_hdr = hdr;
            bus64.in_hdr_valid = hv; bus64.in_gbx_sync = gs;
        end else begin
            bus32.in_data = data[31:0]; bus32.in_data_valid = dv; bus32.in_hdr = hdr;
            bus32.in_hdr_valid = hv; bus32.in_gbx_sync = gs;
        end
        @(posedge clk); #1;

        got = exp_q.pop_front();
        if (mode == 64) begin
            check("out_data", bus64.out_data, got.word);
            check("out_valid", bus64.out_data_valid, 1'b1);
            check("stat_err", stat_err64, got.err);
`ifdef TAXI_ETH_TX_GBX_ERR_CNT_EN
            check("err_count", {48'h0, err_cnt64}, 64'(err_pulses));
`endif
        end else begin
            check("out_data", {32'h0, bus32.out_data}, got.word);
            check("out_valid", bus32.out_data_valid, 1'b1);
            check("stat_err", stat_err32, got.err);
`ifdef TAXI_ETH_TX_GBX_ERR_CNT_EN
            check("err_count", {48'h0, err_cnt32}, 64'(err_pulses));
`endif
        end
        tb_seq = (tb_seq == 32) ? 0 : tb_seq + 1;
        since_rst++;
    endtask

    // kind: 0 normal, 1 underrun, 2 valid on stall slot, 3 wrong sync, 4 stall+sync together
    task automatic slot64(input int kind);
        logic [63:0] d;
        logic [1:0]  h;
        logic        dv, gs;
        d  = {$urandom, $urandom};
        h  = 2'($urandom_range(1, 2));
        dv = (tb_seq != 32);
        gs = (tb_seq == 0);
        case (kind)
            1: dv = 1'b0;
            2: dv = 1'b1;
            3: gs = ~gs;
            4: begin dv = 1'b1; gs = 1'b1; end
            default: ;
        endcase
        step(dv, 1'b1, h, d, gs);
    endtask

    // kind: 0 normal, 1 underrun, 5 wrong header-valid; fixed selects all-ones payload, hdr 10
    task automatic slot32(input int kind, input logic fixed);
        logic        dv, gs, hv, even;
        logic [31:0] half;
        even = (tb_seq % 2 == 0);
        if (tb_seq != 32 && even) begin
            blk32 = fixed ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            hdr32 = fixed ? 2'b10 : 2'($urandom_range(1, 2));
        end
        half = even ? blk32[31:0] : blk32[63:32];
        dv = (tb_seq != 32);
        gs = (tb_seq == 0);
        hv = even && (tb_seq != 32);
        case (kind)
            1: dv = 1'b0;
            5: hv = ~hv;
            default: ;
        endcase
        step(dv, hv, hdr32, {32'h0, half}, gs);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        blk32 = '0;
        hdr32 = 2'b01;
        vecs[0] = '{2'b01, 64'h0123_4567_89AB_CDEF, 64'h048D_159E_26AF_37BD, 64'h0};
        vecs[1] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'h3};
        vecs[2] = '{2'b11, 64'h0,                   64'h3,                   64'h0};
        vecs[3] = '{2'b00, 64'h8000_0000_0000_0001, 64'h4,                   64'h2};

        // First two words of a fresh sequence for fixed blocks (second block all zero).
        for (int i = 0; i < 4; i++) begin
            do_reset();
            step(1'b1, 1'b1, vecs[i].hdr, vecs[i].data, 1'b1);
            check("vec_word0", bus64.out_data, vecs[i].word0);
            step(1'b1, 1'b1, 2'b00, 64'h0, 1'b0);
            check("vec_word1", bus64.out_data, vecs[i].word1);
        end

        // Clean run with the stall honoured; request timing against fixed cycle numbers.
        do_reset();
        for (int c = 0; c < 100; c++) slot64(0);
        check("stall_cycles_n", 64'(stall_cyc.size()), 64'd3);
        check("stall_cycle_a", 64'(stall_cyc[0]), 64'd31);
        check("stall_cycle_b", 64'(stall_cyc[1]), 64'd64);
        check("stall_cycle_c", 64'(stall_cyc[2]), 64'd97);
        check("sync_cycle_a", 64'(sync_cyc[0]), 64'd32);
        check("sync_cycle_b", 64'(sync_cyc[1]), 64'd65);

        // Protocol violations, then a reset landing on slot 17.
        do_reset();
        for (int c = 0; c < 83; c++) begin
            slot64((c == 5) ? 1 : (c == 32) ? 2 : (c == 36) ? 3 : (c == 65) ? 4 : 0);
        end
        check("mid_reset_slot", 64'(tb_seq), 64'd17);
        do_reset();
        for (int c = 0; c < 40; c++) slot64((c == 0) ? 3 : 0);

        // 32-bit gearbox: 16 all-ones blocks, then random blocks with violations.
        mode = 32;
        do_reset();
        for (int c = 0; c < 72; c++) begin
            slot32((c == 40) ? 5 : (c == 45) ? 1 : 0, c < 32);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
